// File: rtl/spi_pkg.sv
// Shared SPI types, frame constant and CPOL/CPHA edge decode.
// Reused by both the master and the slave responder.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam int SPI_FRAME_BITS = 8;

    typedef struct packed {
        logic sample;
        logic shift;
    } spi_edge_t;

    // Leading edge leaves the idle level, trailing edge returns to it.
    function automatic spi_edge_t spi_edge_decode(
        input logic cpol,
        input logic cpha,
        input logic rise,
        input logic fall
    );
        spi_edge_t e;
        logic      lead;
        logic      trail;
        lead     = cpol ? fall : rise;
        trail    = cpol ? rise : fall;
        e.sample = cpha ? trail : lead;
        e.shift  = cpha ? lead : trail;
        return e;
    endfunction

endpackage

// File: rtl/spi_slave_responder_if.sv
// Local byte port of the SPI slave responder.
// Slave modport is the responder, master modport is local logic.
interface spi_slave_responder_if;
    import spi_pkg::*;

    logic [SPI_FRAME_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic [SPI_FRAME_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      tx_underrun;

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        output tx_underrun
    );

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        input  tx_underrun
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Pin synchronizer plus history flop with rise/fall detect.
// INIT sets the reset level of the whole chain.
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              hist;

    // Shift the pin through the chain and keep one cycle of history.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {STAGES{INIT}};
            hist <= INIT;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            hist <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~hist;
    assign fall = ~sync[STAGES-1] & hist;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI slave responder: oversampled SCLK/SS/MOSI, 8-bit frames.
// Define SPI_RESP_LSBFE_EN for the per-frame LSB-first option.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int                        SYNC_STAGES = 2,
    parameter logic [SPI_FRAME_BITS-1:0] IDLE_FILL   = 8'hFF
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   cpol,
    input  logic                   cpha,
`ifdef SPI_RESP_LSBFE_EN
    input  logic                   lsbfe,
`endif
    input  logic                   sclk_in,
    input  logic                   ss_n_in,
    input  logic                   mosi_in,
    output logic                   miso_out,
    output logic                   miso_oe,
    output logic                   busy,
    spi_slave_responder_if.slave   bus
);

    localparam int            MSB      = SPI_FRAME_BITS - 1;
    localparam int            CW       = $clog2(SPI_FRAME_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(SPI_FRAME_BITS - 1);

    spi_state_e               state_q;
    spi_state_e               state_d;
    logic                     sclk_rise;
    logic                     sclk_fall;
    logic                     ss_rise;
    logic                     ss_fall;
    logic [SYNC_STAGES-1:0]   mosi_sync;
    logic                     mosi_s;
    logic                     cpol_q;
    logic                     cpha_q;
`ifdef SPI_RESP_LSBFE_EN
    logic                     lsbfe_q;
`endif
    logic [CW-1:0]            bit_cnt;
    logic [MSB:0]             tx_sh;
    logic [MSB:0]             rx_sh;
    logic [MSB:0]             tx_shifted;
    logic [MSB:0]             rx_next;
    logic                     miso_bit;
    spi_edge_t                edges;
    logic                     active;
    logic                     start;
    logic                     sample_en;
    logic                     shift_en;
    logic                     frame_end;
    logic                     load;

    spi_sync_edge #(
        .STAGES (SYNC_STAGES),
        .INIT   (1'b0)
    ) u_sclk (
        .clk    (PCLK),
        .rst    (PRESET),
        .din    (sclk_in),
        .rise   (sclk_rise),
        .fall   (sclk_fall)
    );

    spi_sync_edge #(
        .STAGES (SYNC_STAGES),
        .INIT   (1'b1)
    ) u_ss (
        .clk    (PCLK),
        .rst    (PRESET),
        .din    (ss_n_in),
        .rise   (ss_rise),
        .fall   (ss_fall)
    );

    // MOSI synchronizer, same depth so it lines up with sclk edges.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
        end
    end

    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // A shift edge while bit_cnt is 0 belongs to a freshly loaded
    // byte whose MSB is already on MISO, so it must not advance it.
    assign active    = (state_q == ACTIVE);
    assign start     = ~active & ss_fall;
    assign edges     = spi_edge_decode(cpol_q, cpha_q,
                                       sclk_rise, sclk_fall);
    assign sample_en = active & edges.sample;
    assign shift_en  = active & edges.shift & (bit_cnt != '0);
    assign frame_end = sample_en & (bit_cnt == LAST_BIT);
    assign load      = start | (frame_end & ~ss_rise);

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: select starts a frame, deselect aborts it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall) state_d = ACTIVE;
            ACTIVE:  if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift direction muxing for TX, RX and the MISO bit.
    always_comb begin
`ifdef SPI_RESP_LSBFE_EN
        if (lsbfe_q) begin
            tx_shifted = {1'b0, tx_sh[MSB:1]};
            rx_next    = {mosi_s, rx_sh[MSB:1]};
            miso_bit   = tx_sh[0];
        end else begin
            tx_shifted = {tx_sh[MSB-1:0], 1'b0};
            rx_next    = {rx_sh[MSB-1:0], mosi_s};
            miso_bit   = tx_sh[MSB];
        end
`else
        tx_shifted = {tx_sh[MSB-1:0], 1'b0};
        rx_next    = {rx_sh[MSB-1:0], mosi_s};
        miso_bit   = tx_sh[MSB];
`endif
    end

    // Pin-side outputs follow the FSM state.
    always_comb begin
        busy     = active;
        miso_oe  = active;
        miso_out = active & miso_bit;
    end

    // Frame datapath: mode latch, counters, shifters, byte port.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cpol_q          <= 1'b0;
            cpha_q          <= 1'b0;
`ifdef SPI_RESP_LSBFE_EN
            lsbfe_q         <= 1'b0;
`endif
            bit_cnt         <= '0;
            tx_sh           <= '0;
            rx_sh           <= '0;
            bus.rx_data     <= '0;
            bus.rx_valid    <= 1'b0;
            bus.tx_ready    <= 1'b0;
            bus.tx_underrun <= 1'b0;
        end else begin
            bus.rx_valid    <= frame_end;
            bus.tx_ready    <= load & bus.tx_valid;
            bus.tx_underrun <= load & ~bus.tx_valid;
            if (start) begin
                cpol_q  <= cpol;
                cpha_q  <= cpha;
`ifdef SPI_RESP_LSBFE_EN
                lsbfe_q <= lsbfe;
`endif
            end
            if (frame_end) begin
                bus.rx_data <= rx_next;
            end
            if (start | ss_rise) begin
                bit_cnt <= '0;
            end else if (sample_en) begin
                bit_cnt <= bit_cnt + CW'(1);
            end
            if (sample_en) begin
                rx_sh <= rx_next;
            end
            if (load) begin
                tx_sh <= bus.tx_valid ? bus.tx_data : IDLE_FILL;
            end else if (shift_en) begin
                tx_sh <= tx_shifted;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder with a bit-banged master.
// Define SPI_RESP_LSBFE_EN to include the LSB-first scenario.
module tb_spi_slave_responder;

    logic PCLK = 1'b0;
    logic PRESET;
    logic cpol;
    logic cpha;
`ifdef SPI_RESP_LSBFE_EN
    logic lsbfe;
`endif
    logic sclk_in;
    logic ss_n_in;
    logic mosi_in;
    logic miso_out;
    logic miso_oe;
    logic busy;
    logic mst_lsb;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int rx_cnt = 0;
    int rdy_cnt = 0;
    int unr_cnt = 0;
    int rx_t_last = 0;
    int rx_t_prev = 0;
    logic [7:0] rx_b_last = 8'h00;
    logic [7:0] rx_b_prev = 8'h00;

    spi_slave_responder_if bus();

    spi_slave_responder dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .cpol     (cpol),
        .cpha     (cpha),
`ifdef SPI_RESP_LSBFE_EN
        .lsbfe    (lsbfe),
`endif
        .sclk_in  (sclk_in),
        .ss_n_in  (ss_n_in),
        .mosi_in  (mosi_in),
        .miso_out (miso_out),
        .miso_oe  (miso_oe),
        .busy     (busy),
        .bus      (bus)
    );

    always #5 PCLK = ~PCLK;

    // Count and log the byte-port pulses away from the active edge.
    always @(negedge PCLK) begin
        cyc <= cyc + 1;
        if (bus.rx_valid) begin
            rx_cnt    <= rx_cnt + 1;
            rx_t_prev <= rx_t_last;
            rx_t_last <= cyc;
            rx_b_prev <= rx_b_last;
            rx_b_last <= bus.rx_data;
        end
        if (bus.tx_ready) rdy_cnt <= rdy_cnt + 1;
        if (bus.tx_underrun) unr_cnt <= unr_cnt + 1;
    end

    task automatic half();
        repeat (4) @(negedge PCLK);
    endtask

    task automatic set_mode(input logic p, input logic h);
        cpol    = p;
        cpha    = h;
        sclk_in = p;
        repeat (6) @(negedge PCLK);
    endtask

    task automatic ss_assert();
        ss_n_in = 1'b0;
        half();
    endtask

    task automatic ss_release();
        half();
        ss_n_in = 1'b1;
        repeat (8) @(negedge PCLK);
    endtask

    // Master shifting n bits; end_ss raises SS with the last edge.
    task automatic spi_bits(input logic [7:0] mo, input int n,
                            input bit end_ss, output logic [7:0] mi);
        int idx;
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            idx = mst_lsb ? i : 7 - i;
            if (!cpha) begin
                mosi_in = mo[idx];
                half();
                mi[idx] = miso_out;
                sclk_in = ~cpol;
                half();
                sclk_in = cpol;
            end else begin
                sclk_in = ~cpol;
                mosi_in = mo[idx];
                half();
                mi[idx] = miso_out;
                sclk_in = cpol;
                if (end_ss && i == n - 1) ss_n_in = 1'b1;
                half();
            end
        end
    endtask

    task automatic test_reset();
        PRESET       = 1'b1;
        ss_n_in      = 1'b1;
        sclk_in      = 1'b0;
        mosi_in      = 1'b0;
        cpol         = 1'b0;
        cpha         = 1'b0;
        mst_lsb      = 1'b0;
`ifdef SPI_RESP_LSBFE_EN
        lsbfe        = 1'b0;
`endif
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (4) @(negedge PCLK);
        tests++;
        if (miso_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_miso_out got %b want 0", miso_out);
        end
        tests++;
        if (miso_oe !== 1'b0) begin
            fails++;
            $display("FAIL reset_miso_oe got %b want 0", miso_oe);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        tests++;
        if (bus.tx_ready !== 1'b0 || bus.tx_underrun !== 1'b0) begin
            fails++;
            $display("FAIL reset_tx got %b%b want 00",
                     bus.tx_ready, bus.tx_underrun);
        end
        tests++;
        if (bus.rx_valid !== 1'b0 || bus.rx_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_rx got %b/%h want 0/00",
                     bus.rx_valid, bus.rx_data);
        end
        PRESET = 1'b0;
        repeat (4) @(negedge PCLK);
    endtask

    task automatic test_mode0();
        logic [7:0] m;
        int r0, t0, u0;
        set_mode(1'b0, 1'b0);
        bus.tx_data  = 8'hA5;
        bus.tx_valid = 1'b1;
        r0 = rx_cnt;
        t0 = rdy_cnt;
        u0 = unr_cnt;
        ss_assert();
        tests++;
        if (miso_oe !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL m0_select got oe=%b busy=%b want 1/1",
                     miso_oe, busy);
        end
        bus.tx_valid = 1'b0;
        spi_bits(8'h3C, 8, 1'b0, m);
        ss_release();
        tests++;
        if (m !== 8'hA5) begin
            fails++;
            $display("FAIL m0_miso got %h want a5", m);
        end
        tests++;
        if (bus.rx_data !== 8'h3C) begin
            fails++;
            $display("FAIL m0_rx_data got %h want 3c", bus.rx_data);
        end
        tests++;
        if (rx_cnt - r0 !== 1) begin
            fails++;
            $display("FAIL m0_rx_pulses got %0d want 1", rx_cnt - r0);
        end
        tests++;
        if (rdy_cnt - t0 !== 1) begin
            fails++;
            $display("FAIL m0_tx_ready got %0d want 1", rdy_cnt - t0);
        end
        tests++;
        if (unr_cnt - u0 !== 1) begin
            fails++;
            $display("FAIL m0_reload_underrun got %0d want 1",
                     unr_cnt - u0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m1, m2;
        int r0, t0;
        set_mode(1'b1, 1'b1);
        bus.tx_data  = 8'hC3;
        bus.tx_valid = 1'b1;
        r0 = rx_cnt;
        t0 = rdy_cnt;
        ss_assert();
        bus.tx_data = 8'h5A;
        spi_bits(8'h01, 8, 1'b0, m1);
        spi_bits(8'h80, 8, 1'b1, m2);
        repeat (8) @(negedge PCLK);
        bus.tx_valid = 1'b0;
        tests++;
        if (m1 !== 8'hC3 || m2 !== 8'h5A) begin
            fails++;
            $display("FAIL b2b_miso got %h %h want c3 5a", m1, m2);
        end
        tests++;
        if (rx_cnt - r0 !== 2) begin
            fails++;
            $display("FAIL b2b_rx_pulses got %0d want 2", rx_cnt - r0);
        end
        tests++;
        if (rx_b_prev !== 8'h01 || rx_b_last !== 8'h80) begin
            fails++;
            $display("FAIL b2b_rx_bytes got %h %h want 01 80",
                     rx_b_prev, rx_b_last);
        end
        tests++;
        if (rx_t_last - rx_t_prev !== 64) begin
            fails++;
            $display("FAIL b2b_spacing got %0d want 64",
                     rx_t_last - rx_t_prev);
        end
        tests++;
        if (rdy_cnt - t0 !== 2) begin
            fails++;
            $display("FAIL b2b_tx_ready got %0d want 2", rdy_cnt - t0);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] m;
        int r0, t0, u0;
        set_mode(1'b0, 1'b1);
        bus.tx_valid = 1'b0;
        r0 = rx_cnt;
        t0 = rdy_cnt;
        u0 = unr_cnt;
        ss_assert();
        spi_bits(8'h5A, 8, 1'b1, m);
        repeat (8) @(negedge PCLK);
        tests++;
        if (m !== 8'hFF) begin
            fails++;
            $display("FAIL unr_miso got %h want ff", m);
        end
        tests++;
        if (unr_cnt - u0 !== 1 || rdy_cnt - t0 !== 0) begin
            fails++;
            $display("FAIL unr_pulses got unr=%0d rdy=%0d want 1/0",
                     unr_cnt - u0, rdy_cnt - t0);
        end
        tests++;
        if (rx_cnt - r0 !== 1 || bus.rx_data !== 8'h5A) begin
            fails++;
            $display("FAIL unr_rx got %0d/%h want 1/5a",
                     rx_cnt - r0, bus.rx_data);
        end
    endtask

    task automatic test_abort();
        logic [7:0] m;
        int r0;
        set_mode(1'b1, 1'b0);
        bus.tx_data  = 8'h77;
        bus.tx_valid = 1'b1;
        r0 = rx_cnt;
        ss_assert();
        bus.tx_valid = 1'b0;
        spi_bits(8'hFF, 5, 1'b0, m);
        half();
        ss_n_in = 1'b1;
        repeat (2) @(negedge PCLK);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_busy_hold got %b want 1", busy);
        end
        @(negedge PCLK);
        tests++;
        if (busy !== 1'b0 || miso_oe !== 1'b0) begin
            fails++;
            $display("FAIL abort_drop got busy=%b oe=%b want 0/0",
                     busy, miso_oe);
        end
        repeat (8) @(negedge PCLK);
        tests++;
        if (rx_cnt - r0 !== 0) begin
            fails++;
            $display("FAIL abort_no_rx got %0d want 0", rx_cnt - r0);
        end
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        ss_assert();
        bus.tx_valid = 1'b0;
        spi_bits(8'h96, 8, 1'b0, m);
        ss_release();
        tests++;
        if (rx_cnt - r0 !== 1 || rx_b_last !== 8'h96) begin
            fails++;
            $display("FAIL abort_next_rx got %0d/%h want 1/96",
                     rx_cnt - r0, rx_b_last);
        end
        tests++;
        if (m !== 8'h3C) begin
            fails++;
            $display("FAIL abort_next_miso got %h want 3c", m);
        end
    endtask

`ifdef SPI_RESP_LSBFE_EN
    task automatic test_lsbfe();
        logic [7:0] m;
        set_mode(1'b0, 1'b0);
        lsbfe        = 1'b1;
        mst_lsb      = 1'b1;
        bus.tx_data  = 8'h01;
        bus.tx_valid = 1'b1;
        ss_assert();
        bus.tx_valid = 1'b0;
        spi_bits(8'h80, 8, 1'b0, m);
        ss_release();
        lsbfe   = 1'b0;
        mst_lsb = 1'b0;
        tests++;
        if (m[0] !== 1'b1 || m !== 8'h01) begin
            fails++;
            $display("FAIL lsb_miso got %h want 01", m);
        end
        tests++;
        if (bus.rx_data !== 8'h80) begin
            fails++;
            $display("FAIL lsb_rx got %h want 80", bus.rx_data);
        end
    endtask
`endif

    task automatic test_preset();
        logic [7:0] m;
        int r0;
        set_mode(1'b0, 1'b0);
        bus.tx_data  = 8'hA5;
        bus.tx_valid = 1'b1;
        ss_assert();
        bus.tx_valid = 1'b0;
        spi_bits(8'hE7, 4, 1'b0, m);
        PRESET  = 1'b1;
        ss_n_in = 1'b1;
        @(negedge PCLK);
        tests++;
        if (busy !== 1'b0 || miso_oe !== 1'b0 || miso_out !== 1'b0) begin
            fails++;
            $display("FAIL preset_pins got %b%b%b want 000",
                     busy, miso_oe, miso_out);
        end
        tests++;
        if (bus.rx_data !== 8'h00 || bus.rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL preset_rx got %h/%b want 00/0",
                     bus.rx_data, bus.rx_valid);
        end
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        repeat (4) @(negedge PCLK);
        r0 = rx_cnt;
        bus.tx_data  = 8'h69;
        bus.tx_valid = 1'b1;
        ss_assert();
        bus.tx_valid = 1'b0;
        spi_bits(8'hE7, 8, 1'b0, m);
        ss_release();
        tests++;
        if (m !== 8'h69) begin
            fails++;
            $display("FAIL preset_next_miso got %h want 69", m);
        end
        tests++;
        if (rx_cnt - r0 !== 1 || bus.rx_data !== 8'hE7) begin
            fails++;
            $display("FAIL preset_next_rx got %0d/%h want 1/e7",
                     rx_cnt - r0, bus.rx_data);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_back_to_back();
        test_underrun();
        test_abort();
`ifdef SPI_RESP_LSBFE_EN
        test_lsbfe();
`endif
        test_preset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
